// File: rtl/led_btn_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_btn_ctrl_pkg : LED modes and register map for led_btn_ctrl      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package led_btn_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ON     = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam int MAX_LEDS = 8;
    localparam int MAX_BTNS = 4;

    localparam logic [31:0] ADDR_MODE_BASE   = 32'h0000_0000;
    localparam logic [31:0] ADDR_PERIOD_BASE = 32'h0000_0020;
    localparam logic [31:0] ADDR_LED_STATUS  = 32'h0000_0040;
    localparam logic [31:0] ADDR_PRESS_CNT   = 32'h0000_0044;
    localparam logic [31:0] ADDR_BTN_STATUS  = 32'h0000_0048;

    function automatic logic [31:0] mode_addr(input int idx);
        return ADDR_MODE_BASE + 32'(idx * 4);
    endfunction

    function automatic logic [31:0] period_addr(input int idx);
        return ADDR_PERIOD_BASE + 32'(idx * 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce : 2-FF synchroniser, debouncer and press pulse         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES_P = 1250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES_P);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES_P - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/led_btn_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_btn_ctrl : register-controlled LEDs with debounced buttons      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module led_btn_ctrl
    import led_btn_ctrl_pkg::*;
#(
    parameter int NR_OF_LEDS_P      = 4,
    parameter int NR_OF_BTNS_P      = 4,
    parameter int DEBOUNCE_CYCLES_P = 1250000,
    parameter int ADDR_WIDTH_P      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NR_OF_BTNS_P-1:0] btn,
    output logic [NR_OF_LEDS_P-1:0] led,
    input  logic                    reg_wr_en,
    input  logic [ADDR_WIDTH_P-1:0] reg_wr_addr,
    input  logic [31:0]             reg_wr_data,
    input  logic                    reg_rd_en,
    input  logic [ADDR_WIDTH_P-1:0] reg_rd_addr,
    output logic [31:0]             reg_rd_data,
    output logic                    reg_rd_valid
);

    logic [MAX_BTNS-1:0] pulse_w;
    logic [MAX_BTNS-1:0] level_w;
    logic [MAX_LEDS-1:0] pulse_ext_w;

    for (genvar j = 0; j < MAX_BTNS; j++) begin : g_btn
        if (j < NR_OF_BTNS_P) begin : g_inst
            btn_debounce #(
                .DEBOUNCE_CYCLES_P(DEBOUNCE_CYCLES_P)
            ) u_btn_debounce (
                .clk    (clk),
                .rst_n  (rst_n),
                .btn_i  (btn[j]),
                .level_o(level_w[j]),
                .press_o(pulse_w[j])
            );
        end else begin : g_tie
            assign level_w[j] = 1'b0;
            assign pulse_w[j] = 1'b0;
        end
    end

    assign pulse_ext_w = MAX_LEDS'(pulse_w);

    mode_e                   mode_q   [NR_OF_LEDS_P];
    mode_e                   mode_d   [NR_OF_LEDS_P];
    logic [31:0]             period_q [NR_OF_LEDS_P];
    logic [31:0]             period_d [NR_OF_LEDS_P];
    logic [31:0]             blink_q  [NR_OF_LEDS_P];
    logic [31:0]             blink_d  [NR_OF_LEDS_P];
    logic [NR_OF_LEDS_P-1:0] led_q, led_d;
    logic [3:0][7:0]         press_q, press_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    rd_valid_q;

    logic [31:0]             wr_addr_w, rd_addr_w;
    logic [NR_OF_LEDS_P-1:0] wr_mode_w, wr_per_w;
    logic                    wr_clr_w;

    always_comb begin
        wr_addr_w = 32'(reg_wr_addr);
        rd_addr_w = 32'(reg_rd_addr);
        wr_mode_w = '0;
        wr_per_w  = '0;
        for (int i = 0; i < NR_OF_LEDS_P; i++) begin
            wr_mode_w[i] = reg_wr_en && (wr_addr_w == mode_addr(i));
            wr_per_w[i]  = reg_wr_en && (wr_addr_w == period_addr(i));
        end
        wr_clr_w = reg_wr_en && (wr_addr_w == ADDR_PRESS_CNT);
    end

    // LED behaviour follows the mode that will be in force after this edge.
    always_comb begin
        led_d = led_q;
        for (int i = 0; i < NR_OF_LEDS_P; i++) begin
            mode_d[i]   = wr_mode_w[i] ? mode_e'(reg_wr_data[1:0]) : mode_q[i];
            period_d[i] = wr_per_w[i] ? reg_wr_data : period_q[i];
            blink_d[i]  = '0;
            case (mode_d[i])
                MODE_OFF:    led_d[i] = 1'b0;
                MODE_ON:     led_d[i] = 1'b1;
                MODE_TOGGLE: if (pulse_ext_w[i]) led_d[i] = ~led_q[i];
                default: begin
                    if (!wr_mode_w[i] && !wr_per_w[i] && period_q[i] != 32'd0) begin
                        if (blink_q[i] == period_q[i] - 32'd1) begin
                            led_d[i] = ~led_q[i];
                        end else begin
                            blink_d[i] = blink_q[i] + 32'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        press_d = press_q;
        for (int j = 0; j < MAX_BTNS; j++) begin
            if (wr_clr_w)        press_d[j] = {7'd0, pulse_w[j]};
            else if (pulse_w[j]) press_d[j] = press_q[j] + 8'd1;
        end
    end

    // Reads sample the pre-write register contents.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NR_OF_LEDS_P; i++) begin
            if (rd_addr_w == mode_addr(i))   rd_data_d = {30'd0, mode_q[i]};
            if (rd_addr_w == period_addr(i)) rd_data_d = period_q[i];
        end
        if (rd_addr_w == ADDR_LED_STATUS) rd_data_d = 32'(led_q);
        if (rd_addr_w == ADDR_PRESS_CNT)  rd_data_d = press_q;
        if (rd_addr_w == ADDR_BTN_STATUS) rd_data_d = 32'(level_w);
        if (!reg_rd_en)                   rd_data_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_OF_LEDS_P; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= '0;
                blink_q[i]  <= '0;
            end
            led_q      <= '0;
            press_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NR_OF_LEDS_P; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                blink_q[i]  <= blink_d[i];
            end
            led_q      <= led_d;
            press_q    <= press_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= reg_rd_en;
        end
    end

    assign led          = led_q;
    assign reg_rd_data  = rd_data_q;
    assign reg_rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_led_btn_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_led_btn_ctrl : scoreboard bench for led_btn_ctrl                 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_led_btn_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  btn;
    logic [3:0]  led;
    logic        reg_wr_en;
    logic [7:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        reg_rd_en;
    logic [7:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        reg_rd_valid;

    led_btn_ctrl #(
        .NR_OF_LEDS_P     (4),
        .NR_OF_BTNS_P     (4),
        .DEBOUNCE_CYCLES_P(4),
        .ADDR_WIDTH_P     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .led         (led),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .reg_rd_valid(reg_rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every response is matched against the oldest outstanding read.
    always @(negedge clk) begin
        if (reg_rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got valid with data %h, expected no response", reg_rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("rd_%02h", e.addr), reg_rd_data, e.exp);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        reg_rd_en   = 1'b1;
        reg_rd_addr = a;
        exp_q.push_back('{addr: a, exp: e});
        @(posedge clk);
        #1;
        reg_rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_wr_en   = 1'b1;
        reg_wr_addr = a;
        reg_wr_data = d;
        @(posedge clk);
        #1;
        reg_wr_en = 1'b0;
    endtask

    task automatic press3();
        btn[3] = 1'b1;
        idle(7);
        btn[3] = 1'b0;
        idle(8);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] zero_addrs [13];
        zero_addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24,
                       8'h28, 8'h2C, 8'h40, 8'h44, 8'h48, 8'h4C};
        rst_n = 1'b0;
        btn = '0;
        reg_wr_en = 1'b0; reg_wr_addr = '0; reg_wr_data = '0;
        reg_rd_en = 1'b0; reg_rd_addr = '0;
        #20;
        chk("reset_led", led, 4'h0);
        chk("reset_valid", reg_rd_valid, 1'b0);
        chk("reset_rdata", reg_rd_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        foreach (zero_addrs[k]) rd(zero_addrs[k], 32'h0);

        // Toggle LED 1 with one debounced press of button 1.
        wr(8'h04, 32'd2);
        btn[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("toggle_led1_c%0d", k), led[1], (k >= 7) ? 1'b1 : 1'b0);
        end
        btn[1] = 1'b0;
        idle(8);
        rd(8'h44, 32'h0000_0100);
        rd(8'h48, 32'h0);
        rd(8'h40, 32'h2);

        // Glitch shorter than the debounce window.
        btn[0] = 1'b1;
        idle(3);
        btn[0] = 1'b0;
        idle(8);
        rd(8'h44, 32'h0000_0100);
        chk("glitch_led", led, 4'h2);

        // Blink LED 2 with half-period 5, then freeze with period 0.
        wr(8'h08, 32'd3);
        wr(8'h28, 32'd5);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            chk($sformatf("blink_led2_c%0d", k), led[2], ((k / 5) % 2 == 1) ? 1'b1 : 1'b0);
        end
        wr(8'h28, 32'd0);
        idle(12);
        chk("blink_frozen", led, 4'h6);
        rd(8'h40, 32'h6);

        // Wrap of the button-3 counter, then press coinciding with clear.
        for (int p = 0; p < 255; p++) press3();
        rd(8'h44, 32'hFF00_0100);
        press3();
        rd(8'h44, 32'h0000_0100);
        btn[3] = 1'b1;
        idle(6);
        wr(8'h44, 32'hDEAD_BEEF);
        idle(1);
        btn[3] = 1'b0;
        idle(8);
        rd(8'h44, 32'h0100_0000);

        // Read and write to one address in the same cycle; RO/unmapped writes.
        reg_rd_en = 1'b1; reg_rd_addr = 8'h00;
        reg_wr_en = 1'b1; reg_wr_addr = 8'h00; reg_wr_data = 32'd1;
        exp_q.push_back('{addr: 8'h00, exp: 32'h0});
        @(posedge clk); #1;
        reg_rd_en = 1'b0; reg_wr_en = 1'b0;
        chk("on_led0", led[0], 1'b1);
        rd(8'h00, 32'h1);
        wr(8'h40, 32'hF);
        wr(8'h48, 32'hF);
        wr(8'h10, 32'h3);
        rd(8'h40, 32'h7);
        rd(8'h48, 32'h0);
        rd(8'h10, 32'h0);
        rd(8'h08, 32'h3);
        rd(8'h04, 32'h2);

        // Reset in the middle of a blink while LED 2 is lit.
        wr(8'h28, 32'd5);
        idle(2);
        chk("preblink_led2", led[2], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_led", led, 4'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        rd(8'h08, 32'h0);
        rd(8'h28, 32'h0);
        rd(8'h44, 32'h0);
        rd(8'h40, 32'h0);
        idle(8);
        chk("post_reset_led", led, 4'h0);
        rd(8'h44, 32'h0);
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_btn_ctrl.md
LED_BTN_CTRL -- requirements
Module: led_btn_ctrl

Interface
REQ-001 SHALL have parameter NR_OF_LEDS_P, default 4, number of LED outputs (legal 1..8).
REQ-002 SHALL have parameter NR_OF_BTNS_P, default 4, number of button inputs (legal 1..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES_P, default 1250000, stable cycles needed to accept a button level (legal >=2).
REQ-004 SHALL have parameter ADDR_WIDTH_P, default 8, register byte-address width.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 btn  input  NR_OF_BTNS_P  raw asynchronous button levels, 1 = pressed.
REQ-008 led  output  NR_OF_LEDS_P  LED drive, 1 = lit, registered.
REQ-009 reg_wr_en / reg_wr_addr / reg_wr_data  input  1 / ADDR_WIDTH_P / 32  single-cycle register write.
REQ-010 reg_rd_en / reg_rd_addr  input  1 / ADDR_WIDTH_P  single-cycle register read request.
REQ-011 reg_rd_data / reg_rd_valid  output  32 / 1  read response.

Function
REQ-012 Register map (word aligned): 0x00+4*i MODE_i [1:0]; 0x20+4*i PERIOD_i [31:0] (half-period, cycles); 0x40 LED_STATUS (RO, led in [NR_OF_LEDS_P-1:0]); 0x44 PRESS_CNT (four 8-bit counters, button j in [8j+7:8j]); 0x48 BTN_STATUS (RO, debounced levels).
REQ-013 MODE encoding SHALL be 0 OFF, 1 ON, 2 TOGGLE, 3 BLINK.
REQ-014 Read: reg_rd_valid SHALL assert exactly one cycle after reg_rd_en with reg_rd_data; unmapped or out-of-range index reads return 0.
REQ-015 Writes to unmapped/RO addresses SHALL be ignored; write to 0x44 (any data) SHALL clear all press counters.
REQ-016 Same-cycle read and write to one address SHALL return the pre-write value.
REQ-017 Each button SHALL pass a 2-FF synchroniser, then a debouncer updating its debounced level only after DEBOUNCE_CYCLES_P consecutive equal synchronised samples.
REQ-018 A press pulse SHALL be one cycle on each debounced 0->1 transition; raw edge to pulse latency 2+DEBOUNCE_CYCLES_P cycles.
REQ-019 Press pulse j SHALL increment PRESS_CNT byte j, wrapping 255->0; pulse coincident with clear yields 1.
REQ-020 OFF/ON: led[i] SHALL be 0/1 from the cycle after MODE_i is written.
REQ-021 TOGGLE: led[i] SHALL invert the cycle after press pulse i; for i >= NR_OF_BTNS_P led[i] holds.
REQ-022 BLINK: per-LED counter counts 0..PERIOD_i-1; at PERIOD_i-1 led[i] inverts and counter returns to 0; PERIOD_i = 0 holds led[i] and counter at 0.
REQ-023 Writing PERIOD_i or MODE_i SHALL clear counter i; counter runs only in BLINK.
REQ-024 Entering TOGGLE or BLINK SHALL keep the current led[i] value as start state.

Reset
REQ-025 On rst_n low: led, all MODE (OFF), PERIOD, counters, PRESS_CNT, debounced levels, synchronisers, reg_rd_data, reg_rd_valid SHALL be 0, asynchronously.
REQ-026 Reset mid-blink or mid-debounce SHALL abort the operation; no press pulse SHALL be produced by reset release.

Structure
REQ-027 Package led_btn_ctrl_pkg SHALL hold the mode enum and register-address constants.
REQ-028 Sub-module btn_debounce (synchroniser, debouncer, press pulse) SHALL be instantiated once per button.

Verification
REQ-029 Reset, read 0x00..0x48 -> all zero; led = 0.
REQ-030 DEBOUNCE_CYCLES_P=4: MODE_1=2, btn[1] high 10 cycles -> led[1] = 1 at cycle 7; PRESS_CNT = 0x00000100.
REQ-031 btn[0] glitch high 3 cycles (DEBOUNCE 4) -> no pulse, PRESS_CNT unchanged.
REQ-032 MODE_2=3, PERIOD_2=5 -> led[2] toggles every 5 cycles; write PERIOD_2=0 -> led[2] frozen.
REQ-033 256 presses on btn[3] -> byte 3 = 0; press coinciding with write 0x44 -> byte 3 = 1.
REQ-034 rst_n low mid-blink with led[2] = 1 -> led = 0 immediately, MODE_2 reads 0 after release.
